// File: rtl/bt656_pattern_tx.sv
// ITU-R BT.656 625-line/50 Hz test-pattern transmitter.
// Emits EAV, blanking, SAV and 4:2:2 picture bytes (Cb Y Cr Y) for either
// 75% colour bars or a flat colour, one byte per 27 MHz clock.
module bt656_pattern_tx #(
   parameter int unsigned H_BLANK  = 280,
   parameter int unsigned N_LINES  = 625,
   parameter int unsigned F_SWITCH = 313,
   parameter int unsigned V1_END   = 22,
   parameter int unsigned V2_START = 311,
   parameter int unsigned V2_END   = 335,
   parameter int unsigned V3_START = 624,
   parameter int unsigned BAR_W    = 90
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       pattern_sel,
   input  logic [7:0] flat_y,
   input  logic [7:0] flat_cb,
   input  logic [7:0] flat_cr,
   output logic [7:0] qd_out,
   output logic       field,
   output logic [9:0] line_cnt,
   output logic       active_video,
   output logic       frame_start
);

   // Horizontal landmarks within one line.
   localparam logic [10:0] SAV_H    = 11'(4 + H_BLANK);
   localparam logic [10:0] PIC_H    = 11'(8 + H_BLANK);
   localparam logic [10:0] LAST_H   = 11'(8 + H_BLANK + 1440 - 1);
   // Vertical landmarks.
   localparam logic [9:0]  LAST_LN  = 10'(N_LINES);
   localparam logic [9:0]  F_LN     = 10'(F_SWITCH);
   localparam logic [9:0]  V1_LN    = 10'(V1_END);
   localparam logic [9:0]  V2S_LN   = 10'(V2_START);
   localparam logic [9:0]  V2E_LN   = 10'(V2_END);
   localparam logic [9:0]  V3_LN    = 10'(V3_START);

   typedef enum logic [1:0] {
      REG_EAV,
      REG_BLANK,
      REG_SAV,
      REG_PIC
   } region_t;

   // Keep picture samples out of the 00/FF range reserved for timing codes.
   function automatic logic [7:0] clamp(input logic [7:0] v);
      if (v == 8'h00)      return 8'h01;
      else if (v == 8'hFF) return 8'hFE;
      else                 return v;
   endfunction

   // Bar index 0..7 for a pixel number, by comparison against bar edges.
   function automatic logic [2:0] bar_of(input logic [9:0] p);
      logic [2:0] b;
      b = 3'd0;
      for (int i = 1; i < 8; i++)
         if (p >= 10'(i * BAR_W)) b = b + 3'd1;
      return b;
   endfunction

   logic [10:0] h;
   logic [9:0]  line;

   // Pattern selection latched once per frame.
   logic        sel_q;
   logic [7:0]  y_q, cb_q, cr_q;

   region_t     region;
   logic        f_bit, v_bit, h_bit;
   logic [7:0]  xy;
   logic [1:0]  ref_idx;
   logic [10:0] blank_off, pic_off;
   logic [9:0]  pix;
   logic [7:0]  bar_y, bar_cb, bar_cr;
   logic [7:0]  smp_y, smp_cb, smp_cr;
   logic [7:0]  byte_nxt;
   logic        av_nxt;
   logic        at_start;

   // Decode the byte, flags and picture sample for the current (line, h).
   // NOTE: every signal gets a default at the top so no path leaves one unassigned and infers a latch.
   always_comb begin
      region    = REG_PIC;
      ref_idx   = 2'd0;
      blank_off = h - 11'd4;
      pic_off   = h - PIC_H;
      pix       = pic_off[10:1];
      byte_nxt  = 8'h10;
      av_nxt    = 1'b0;
      bar_y     = 8'h10;
      bar_cb    = 8'h80;
      bar_cr    = 8'h80;

      if (h < 11'd4)        region = REG_EAV;
      else if (h < SAV_H)   region = REG_BLANK;
      else if (h < PIC_H)   region = REG_SAV;

      f_bit = (line >= F_LN);
      v_bit = (line <= V1_LN) || ((line >= V2S_LN) && (line <= V2E_LN)) || (line >= V3_LN);
      h_bit = (region == REG_EAV);
      xy    = {1'b1, f_bit, v_bit, h_bit, v_bit ^ h_bit, f_bit ^ h_bit,
               f_bit ^ v_bit, f_bit ^ v_bit ^ h_bit};

      case (bar_of(pix))
         3'd0: {bar_y, bar_cb, bar_cr} = 24'hB4_80_80;
         3'd1: {bar_y, bar_cb, bar_cr} = 24'hA2_2C_8E;
         3'd2: {bar_y, bar_cb, bar_cr} = 24'h83_9C_2C;
         3'd3: {bar_y, bar_cb, bar_cr} = 24'h70_48_3A;
         3'd4: {bar_y, bar_cb, bar_cr} = 24'h54_B8_C6;
         3'd5: {bar_y, bar_cb, bar_cr} = 24'h41_64_D4;
         3'd6: {bar_y, bar_cb, bar_cr} = 24'h23_D4_72;
         default: {bar_y, bar_cb, bar_cr} = 24'h10_80_80;
      endcase

      smp_y  = sel_q ? y_q  : bar_y;
      smp_cb = sel_q ? cb_q : bar_cb;
      smp_cr = sel_q ? cr_q : bar_cr;

      if (region == REG_SAV) ref_idx = 2'(h - SAV_H);
      else                   ref_idx = h[1:0];

      case (region)
         REG_EAV, REG_SAV: begin
            case (ref_idx)
               2'd0:    byte_nxt = 8'hFF;
               2'd3:    byte_nxt = xy;
               default: byte_nxt = 8'h00;
            endcase
         end
         REG_BLANK: byte_nxt = blank_off[0] ? 8'h10 : 8'h80;
         default: begin
            if (v_bit) begin
               byte_nxt = pic_off[0] ? 8'h10 : 8'h80;
            end else begin
               av_nxt = 1'b1;
               case (pic_off[1:0])
                  2'd0:    byte_nxt = smp_cb;
                  2'd2:    byte_nxt = smp_cr;
                  default: byte_nxt = smp_y;
               endcase
            end
         end
      endcase

      at_start = (line == 10'd1) && (h == 11'd0);
   end

   // Counters, once-per-frame pattern latches and registered outputs.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h            <= 11'd0;
         line         <= 10'd1;
         sel_q        <= 1'b0;
         y_q          <= 8'h10;
         cb_q         <= 8'h80;
         cr_q         <= 8'h80;
         qd_out       <= 8'h10;
         field        <= 1'b0;
         line_cnt     <= 10'd1;
         active_video <= 1'b0;
         frame_start  <= 1'b0;
      end else if (!en) begin
         h            <= 11'd0;
         line         <= 10'd1;
         qd_out       <= 8'h10;
         field        <= 1'b0;
         line_cnt     <= 10'd1;
         active_video <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         qd_out       <= byte_nxt;
         field        <= f_bit;
         line_cnt     <= line;
         active_video <= av_nxt;
         frame_start  <= at_start;
         if (at_start) begin
            sel_q <= pattern_sel;
            y_q   <= clamp(flat_y);
            cb_q  <= clamp(flat_cb);
            cr_q  <= clamp(flat_cr);
         end
         if (h == LAST_H) begin
            h    <= 11'd0;
            line <= (line == LAST_LN) ? 10'd1 : line + 10'd1;
         end else begin
            h <= h + 11'd1;
         end
      end
   end

endmodule

// File: tb/tb_bt656_pattern_tx.sv
// Self-checking bench for bt656_pattern_tx: a full-size instance for line
// layout, reset and enable, and a short-frame instance for field/frame timing.
module tb_bt656_pattern_tx;

   localparam int LL = 1728;          // bytes per line
   localparam int SN = 12;            // lines per frame in the short instance

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Full-size instance.
   logic       rst_a, en_a, sel_a;
   logic [7:0] fy_a, fcb_a, fcr_a;
   logic [7:0] qd_a;
   logic       fld_a, av_a, fs_a;
   logic [9:0] lc_a;

   // Short-frame instance.
   logic       rst_b, en_b, sel_b;
   logic [7:0] fy_b, fcb_b, fcr_b;
   logic [7:0] qd_b;
   logic       fld_b, av_b, fs_b;
   logic [9:0] lc_b;

   bt656_pattern_tx dut (
      .clk(clk), .rst(rst_a), .en(en_a), .pattern_sel(sel_a),
      .flat_y(fy_a), .flat_cb(fcb_a), .flat_cr(fcr_a),
      .qd_out(qd_a), .field(fld_a), .line_cnt(lc_a),
      .active_video(av_a), .frame_start(fs_a)
   );

   bt656_pattern_tx #(
      .H_BLANK(280), .N_LINES(SN), .F_SWITCH(7), .V1_END(2),
      .V2_START(5), .V2_END(8), .V3_START(11), .BAR_W(90)
   ) dut_s (
      .clk(clk), .rst(rst_b), .en(en_b), .pattern_sel(sel_b),
      .flat_y(fy_b), .flat_cb(fcb_b), .flat_cr(fcr_b),
      .qd_out(qd_b), .field(fld_b), .line_cnt(lc_b),
      .active_video(av_b), .frame_start(fs_b)
   );

   typedef struct {
      int         pos;   // byte index since the frame start
      logic [7:0] qd;
      logic       av;
      logic [9:0] lc;
      logic       fs;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to byte index 'target', sampling 1 time unit after each edge.
   task automatic adv(inout int pos, input int target);
      while (pos < target) begin
         @(posedge clk);
         #1;
         pos++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Layout checks, async reset and enable drop on the full-size instance.
   task automatic run_main();
      int pos;
      en_a = 1'b1;
      step();
      pos = 0;
      foreach (vecs[i]) begin
         adv(pos, vecs[i].pos);
         check($sformatf("vec%0d qd", i), 32'(qd_a), 32'(vecs[i].qd));
         check($sformatf("vec%0d av", i), 32'(av_a), 32'(vecs[i].av));
         check($sformatf("vec%0d line", i), 32'(lc_a), 32'(vecs[i].lc));
         check($sformatf("vec%0d fs", i), 32'(fs_a), 32'(vecs[i].fs));
         check($sformatf("vec%0d field", i), 32'(fld_a), 32'd0);
      end

      // Line 24, h 289: white Y, then reset asserted between edges.
      adv(pos, 23 * LL + 289);
      check("pre-reset qd", 32'(qd_a), 32'hB4);
      check("pre-reset line", 32'(lc_a), 32'd24);
      #2 rst_a = 1'b1;
      #1;
      check("async rst qd", 32'(qd_a), 32'h10);
      check("async rst line", 32'(lc_a), 32'd1);
      check("async rst av", 32'(av_a), 32'd0);
      check("async rst field", 32'(fld_a), 32'd0);
      rst_a = 1'b0;
      step();
      pos = 0;
      check("post-rst qd", 32'(qd_a), 32'hFF);
      check("post-rst fs", 32'(fs_a), 32'd1);

      // One-cycle enable drop at line 1, h 500.
      adv(pos, 500);
      en_a = 1'b0;
      step();
      check("en drop qd", 32'(qd_a), 32'h10);
      check("en drop line", 32'(lc_a), 32'd1);
      check("en drop av", 32'(av_a), 32'd0);
      check("en drop fs", 32'(fs_a), 32'd0);
      en_a = 1'b1;
      step();
      pos = 0;
      check("restart qd", 32'(qd_a), 32'hFF);
      check("restart fs", 32'(fs_a), 32'd1);
      adv(pos, 3);
      check("restart xy", 32'(qd_a), 32'hB6);
   endtask

   // Field flags, frame wrap/period and flat-mode latching on the short instance.
   task automatic run_short();
      int pos;
      bit got;
      int elapsed;
      en_b = 1'b1;
      step();
      pos = 0;
      check("s start qd", 32'(qd_b), 32'hFF);
      check("s start fs", 32'(fs_b), 32'd1);

      adv(pos, 2 * LL + 3);
      check("s l3 eav xy", 32'(qd_b), 32'h9D);

      // Switch to flat mode mid-frame: this frame must stay bars.
      sel_b = 1'b1; fy_b = 8'h00; fcb_b = 8'hFF; fcr_b = 8'h40;
      for (int k = 0; k < 4; k++) begin
         logic [7:0] e;
         case (k)
            0, 2:    e = 8'h80;
            default: e = 8'hB4;
         endcase
         adv(pos, 2 * LL + 288 + k);
         check($sformatf("s bars pic%0d", k), 32'(qd_b), 32'(e));
         check($sformatf("s bars av%0d", k), 32'(av_b), 32'd1);
      end
      adv(pos, 2 * LL + 288 + 180);
      check("s yellow cb", 32'(qd_b), 32'h2C);
      adv(pos, 2 * LL + 288 + 182);
      check("s yellow cr", 32'(qd_b), 32'h8E);

      adv(pos, 6 * LL + 3);
      check("s l7 eav xy", 32'(qd_b), 32'hF1);
      check("s l7 field", 32'(fld_b), 32'd1);
      adv(pos, 8 * LL + 287);
      check("s l9 sav xy", 32'(qd_b), 32'hC7);

      adv(pos, 11 * LL);
      check("s last line", 32'(lc_b), 32'(SN));
      check("s last field", 32'(fld_b), 32'd1);
      check("s last fs", 32'(fs_b), 32'd0);

      // Bounded wait for the next frame_start.
      got = 1'b0;
      elapsed = pos;
      for (int k = 0; k < 2 * LL && !got; k++) begin
         step();
         elapsed++;
         if (fs_b) got = 1'b1;
      end
      check("s frame_start seen", 32'(got), 32'd1);
      check("s frame period", 32'(elapsed), 32'(SN * LL));
      check("s wrap qd", 32'(qd_b), 32'hFF);
      check("s wrap line", 32'(lc_b), 32'd1);
      check("s wrap field", 32'(fld_b), 32'd0);
      pos = 0;

      for (int k = 0; k < 4; k++) begin
         logic [7:0] e;
         case (k)
            0:       e = 8'hFE;
            2:       e = 8'h40;
            default: e = 8'h01;
         endcase
         adv(pos, 2 * LL + 288 + k);
         check($sformatf("s flat pic%0d", k), 32'(qd_b), 32'(e));
      end
   endtask

   initial begin
      rst_a = 1'b1; en_a = 1'b0; sel_a = 1'b0;
      fy_a = 8'h00; fcb_a = 8'h00; fcr_a = 8'h00;
      rst_b = 1'b1; en_b = 1'b0; sel_b = 1'b0;
      fy_b = 8'h00; fcb_b = 8'h00; fcr_b = 8'h00;

      // Expected bytes of the full-size frame, computed by hand.
      vecs.push_back('{0,    8'hFF, 1'b0, 10'd1, 1'b1});
      vecs.push_back('{1,    8'h00, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{2,    8'h00, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{3,    8'hB6, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{4,    8'h80, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{5,    8'h10, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{283,  8'h10, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{284,  8'hFF, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{285,  8'h00, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{286,  8'h00, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{287,  8'hAB, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{288,  8'h80, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{289,  8'h10, 1'b0, 10'd1, 1'b0});
      vecs.push_back('{21 * LL + 1000, 8'h80, 1'b0, 10'd22, 1'b0});
      vecs.push_back('{22 * LL,        8'hFF, 1'b0, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 3,    8'h9D, 1'b0, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 287,  8'h80, 1'b0, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 288,  8'h80, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 289,  8'hB4, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 290,  8'h80, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 291,  8'hB4, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 468,  8'h2C, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 469,  8'hA2, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 470,  8'h8E, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 471,  8'hA2, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 1724, 8'h80, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 1725, 8'h10, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 1726, 8'h80, 1'b1, 10'd23, 1'b0});
      vecs.push_back('{22 * LL + 1727, 8'h10, 1'b1, 10'd23, 1'b0});

      repeat (3) step();
      check("rst qd", 32'(qd_a), 32'h10);
      check("rst line", 32'(lc_a), 32'd1);
      check("rst field", 32'(fld_a), 32'd0);
      check("rst av", 32'(av_a), 32'd0);
      check("rst fs", 32'(fs_a), 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      step();
      check("idle qd", 32'(qd_a), 32'h10);
      check("idle fs", 32'(fs_a), 32'd0);
      check("idle short qd", 32'(qd_b), 32'h10);

      fork
         run_main();
         run_short();
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bt656_pattern_tx.md
Name: bt656_pattern_tx

Overview:
- Generates a complete ITU-R BT.656 625-line/50 Hz 8-bit 4:2:2 byte stream. Each line carries EAV, blanking, SAV and active video, with correct F/V/H and protection bits.
- It is the transmitter counterpart of the BT.656 receive path (adv7180_video_in). It drives the ADV7179 DA bus for encoder bring-up, and serves as a self-test source for the decode/SRAM chain without a live ADV7180.
- Runs in the 27 MHz pixel-clock domain (clk27M_DCMed).

Parameters:
- H_BLANK, 280, blanking bytes between EAV and SAV (total line = 4+H_BLANK+4+1440 = 1728)
- N_LINES, 625, lines per frame
- F_SWITCH, 313, first line with F=1
- V1_END, 22, last line of field-1 top vertical blanking (V=1 on lines 1..V1_END)
- V2_START, 311, first line of the mid-frame V=1 band
- V2_END, 335, last line of the mid-frame V=1 band
- V3_START, 624, first line of the end-of-frame V=1 band (runs to N_LINES)
- BAR_W, 90, pixels per colour bar (8 bars x 90 = 720 pixels)

Ports:
- clk  input  1  27 MHz byte clock
- rst  input  1  reset; asynchronous, active-high
- en  input  1  stream enable (tied to config_done)
- pattern_sel  input  1  0 = 75% colour bars, 1 = flat colour
- flat_y  input  8  flat-mode Y
- flat_cb  input  8  flat-mode Cb
- flat_cr  input  8  flat-mode Cr
- qd_out  output  8  BT.656 byte
- field  output  1  F bit of the byte on qd_out
- line_cnt  output  10  line number (1..625) of the byte on qd_out
- active_video  output  1  1 while qd_out carries an active-picture sample
- frame_start  output  1  one-cycle pulse coincident with the first EAV byte (0xFF) of line 1

Behaviour:

Reset and enable:
- rst=1 (asynchronous) sets:
  - internal counters h=0, line=1
  - qd_out=8'h10, field=0, line_cnt=1, active_video=0, frame_start=0
- en=0 on a clk edge: counters return to (line 1, h 0); outputs take their reset values. Dropping en mid-line aborts the line immediately with no partial-frame completion.
- en=1 on a clk edge:
  - qd_out <= byte(line,h); field, line_cnt and active_video are registered from the same (line,h).
  - Then h advances. At h=1727, h wraps to 0 and line increments; at line N_LINES, line wraps to 1.
- Latency: one cycle from counter state to output. The first edge with en=1 after idle outputs 8'hFF with frame_start=1.

Line layout (h = 0..1727):
- h 0-3: EAV = FF 00 00 XY with H=1
- h 4..3+H_BLANK: blanking; even offset 8'h80, odd offset 8'h10
- next 4 bytes: SAV = FF 00 00 XY with H=0
- last 1440 bytes: picture region, ordered Cb Y Cr Y

Timing flags:
- F = (line >= F_SWITCH).
- V = 1 for lines 1..V1_END, V2_START..V2_END, and V3_START..N_LINES.
- XY = {1, F, V, H, V^H, F^H, F^V, F^V^H}.

Picture region:
- On V=1 lines, the picture region is filled with the 80/10 blanking pattern and active_video=0.
- On V=0 lines, active_video=1 and pixel p = (h-288)>>1.

Bars mode (bar index b = p/BAR_W), values as Y,Cb,Cr:
- 0 white: B4,80,80
- 1 yellow: A2,2C,8E
- 2 cyan: 83,9C,2C
- 3 green: 70,48,3A
- 4 magenta: 54,B8,C6
- 5 red: 41,64,D4
- 6 blue: 23,D4,72
- 7 black: 10,80,80

Flat mode:
- Outputs the latched flat_y, flat_cb and flat_cr values.
- Y values 00/FF are clamped to 01/FE. Cb/Cr values 00/FF are clamped to 01/FE.
- FF and 00 never appear outside timing reference codes.

Input latching:
- pattern_sel and flat_* are latched only when (line 1, h 0) is emitted, so there is no mid-frame tearing.
- The reset value of the latches is bars mode.

Frame timing:
- Frame = 1,080,000 cycles; frame_start period is exactly 1,080,000 cycles.
- Counters are sized 11 bits (h) and 10 bits (line); no other arithmetic overflow is possible.

Test Plan:
- Reset asserted mid-line with en=1 -> outputs change asynchronously to qd_out=10, line_cnt=1, field=0, active_video=0. After release, the first en=1 edge gives FF, frame_start=1.
- en rises -> first 4 bytes FF 00 00 B6 (line 1 EAV), then 80,10 alternating for 280 bytes, then FF 00 00 AB (line 1 SAV). active_video stays 0 through line 22.
- Line 23, bars mode -> EAV XY=9D, SAV XY=80. Picture starts 80 B4 80 B4. Byte offset 180 into the picture is 2C A2 8E A2 (yellow). The last four bytes are 80 10 80 10 (black).
- Field transitions -> line 313 EAV XY=F1, line 336 SAV XY=C7, line 625 wraps to line 1 with field=0. The next frame_start occurs exactly 1,080,000 cycles after the previous one.
- pattern_sel toggled to 1 mid-frame with flat_y=00, flat_cb=FF, flat_cr=40 -> current frame remains bars. From the next frame, the picture is FE 01 40 01.
- en dropped at line 100, h 500 for one cycle, then reasserted -> qd_out=10 for that cycle, and the stream restarts at line 1 EAV (FF, frame_start=1).
